uart_tx_buf: RTL and testbench

UART_TX_BUF -- requirements
Module: uart_tx_buf

---
 rtl/uart_defs.sv | 39 +++
 rtl/uart_tx_fifo.sv | 70 +++++++
 rtl/uart_tx_buf.sv | 154 +++++++++++++++
 tb/tb_uart_tx_buf.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs.sv
// ============================================================================
// Module      : uart_defs
// Description : UART baud rates, divisor decode and TX FSM state encodings.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package uart_defs;

  localparam int unsigned c_BAUD_9600   = 9600;
  localparam int unsigned c_BAUD_19200  = 19200;
  localparam int unsigned c_BAUD_38400  = 38400;
  localparam int unsigned c_BAUD_57600  = 57600;
  localparam int unsigned c_BAUD_115200 = 115200;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Bit period in clock cycles, rounded down; unused selects fall back to 9600.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input logic [2:0] sel);
    int unsigned baud;
    case (sel)
      3'd1:    baud = c_BAUD_19200;
      3'd2:    baud = c_BAUD_38400;
      3'd3:    baud = c_BAUD_57600;
      3'd4:    baud = c_BAUD_115200;
      default: baud = c_BAUD_9600;
    endcase
    return clk_hz / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module      : uart_tx_fifo
// Description : Power-of-two deep byte FIFO with registered full/empty flags.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic             w_wr, w_rd;

  // A write while full is dropped even when a pop frees a slot this cycle.
  assign w_wr = wr_en_i & ~full_q;
  assign w_rd = rd_en_i & ~empty_q;

  always_comb begin
    count_d = count_q;
    case ({w_wr, w_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (w_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;

endmodule

`default_nettype wire

// File: rtl/uart_tx_buf.sv
// ============================================================================
// Module      : uart_tx_buf
// Description : Buffered UART transmitter: byte FIFO, baud counter, frame FSM.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module uart_tx_buf
  import uart_defs::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter int unsigned CLK_HZ     = 50_000_000
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Wr_en,
  input  logic [7:0] Data_byte,
  input  logic [2:0] Baud_sel,
  input  logic       Parity_en,
  input  logic       Parity_odd,
  output logic       Uart_tx,
  output logic       Uart_tx_done,
  output logic       Uart_state,
  output logic       Full,
  output logic       Empty
);

  localparam int DIV_W = $clog2(CLK_HZ / c_BAUD_9600 + 1);

  tx_state_e        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_en_q, par_en_d, par_bit_q, par_bit_d;
  logic             tx_q, tx_d, done_q, done_d, busy_q, busy_d;
  logic             w_pop, w_bit_end, w_empty, w_full;
  logic [7:0]       w_fifo_data;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i     (Clk),
    .rst_ni    (Rst_n),
    .wr_en_i   (Wr_en),
    .wr_data_i (Data_byte),
    .rd_en_i   (w_pop),
    .rd_data_o (w_fifo_data),
    .full_o    (w_full),
    .empty_o   (w_empty)
  );

  assign w_bit_end = (cnt_q == div_q - DIV_W'(1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + DIV_W'(1);
    bit_d     = bit_q;
    shift_d   = shift_q;
    div_d     = div_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    w_pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!w_empty) begin
          state_d = ST_START;
          w_pop   = 1'b1;
        end
      end
      ST_START: if (w_bit_end) begin
        state_d = ST_DATA;
        cnt_d   = '0;
        bit_d   = '0;
      end
      ST_DATA: if (w_bit_end) begin
        cnt_d   = '0;
        shift_d = {1'b0, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = par_en_q ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: if (w_bit_end) begin
        state_d = ST_STOP;
        cnt_d   = '0;
      end
      ST_STOP: if (w_bit_end) begin
        cnt_d = '0;
        if (!w_empty) begin
          state_d = ST_START;
          w_pop   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Line settings are captured with the byte, so mid-frame changes wait a frame.
    if (w_pop) begin
      shift_d   = w_fifo_data;
      div_d     = DIV_W'(baud_div(CLK_HZ, Baud_sel));
      par_en_d  = Parity_en;
      par_bit_d = (^w_fifo_data) ^ Parity_odd;
    end
  end

  // Line outputs trail the state by one cycle so they all come from flops.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_q[0];
      ST_PARITY: tx_d = par_bit_q;
      default:   tx_d = 1'b1;
    endcase
    done_d = (state_q == ST_STOP) && w_bit_end;
    busy_d = (state_q != ST_IDLE);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign Uart_tx      = tx_q;
  assign Uart_tx_done = done_q;
  assign Uart_state   = busy_q;
  assign Full         = w_full;
  assign Empty        = w_empty;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_buf.sv
// ============================================================================
// Module      : tb_uart_tx_buf
// Description : Directed bench for uart_tx_buf with a sampling line receiver.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_buf;
  import uart_defs::*;

  // Reduced clock keeps frames short: divisors 120/60/30/20/10 cycles per bit.
  localparam int          DEPTH     = 8;
  localparam int unsigned TB_CLK_HZ = 1_160_000;

  logic       Clk = 1'b0, Rst_n = 1'b1, Wr_en = 1'b0;
  logic [7:0] Data_byte = 8'h00;
  logic [2:0] Baud_sel = 3'd4;
  logic       Parity_en = 1'b0, Parity_odd = 1'b0;
  logic       Uart_tx, Uart_tx_done, Uart_state, Full, Empty;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_buf #(.FIFO_DEPTH(DEPTH), .CLK_HZ(TB_CLK_HZ)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Wr_en(Wr_en), .Data_byte(Data_byte),
    .Baud_sel(Baud_sel), .Parity_en(Parity_en), .Parity_odd(Parity_odd),
    .Uart_tx(Uart_tx), .Uart_tx_done(Uart_tx_done), .Uart_state(Uart_state),
    .Full(Full), .Empty(Empty)
  );

  always #5 Clk = ~Clk;

  // Line receiver: buffers each frame from its start sample to the done pulse.
  int         cyc = 0, n_s = 0, st_cyc = 0, done_cnt = 0;
  bit         in_frame = 1'b0, rx_par_en = 1'b0;
  bit         sbuf [2048];
  logic [7:0] rx_byte_q[$];
  bit         rx_par_q[$], rx_ok_q[$];
  int         rx_len_q[$], rx_st_q[$], rx_end_q[$];

  task automatic decode_frame();
    int nb, div;
    bit ok, p;
    logic [7:0] b;
    nb = rx_par_en ? 11 : 10;
    div = n_s / nb;
    ok = (div > 0) && (n_s == div * nb);
    b = 8'h00;
    p = 1'b0;
    if (ok) begin
      for (int i = 0; i < n_s; i++)
        if (sbuf[i] != sbuf[(i / div) * div + div / 2]) ok = 1'b0;
      if (sbuf[div / 2] != 1'b0 || sbuf[(nb - 1) * div + div / 2] != 1'b1) ok = 1'b0;
      for (int k = 0; k < 8; k++) b[k] = sbuf[(k + 1) * div + div / 2];
      if (rx_par_en) p = sbuf[9 * div + div / 2];
    end
    rx_byte_q.push_back(b);
    rx_par_q.push_back(p);
    rx_ok_q.push_back(ok);
    rx_len_q.push_back(n_s);
    rx_st_q.push_back(st_cyc);
    rx_end_q.push_back(cyc);
  endtask

  always @(negedge Clk) begin
    cyc++;
    if (!Rst_n) begin
      in_frame = 1'b0;
      n_s = 0;
    end else begin
      if (Uart_tx_done === 1'b1) done_cnt++;
      if (!in_frame && Uart_tx === 1'b0) begin
        in_frame = 1'b1;
        n_s = 0;
        st_cyc = cyc;
      end
      if (in_frame) begin
        if (n_s < 2048) sbuf[n_s] = (Uart_tx === 1'b1);
        n_s++;
        if (Uart_tx_done === 1'b1) begin
          decode_frame();
          in_frame = 1'b0;
        end else if (n_s >= 2048) begin
          in_frame = 1'b0;
        end
      end
    end
  end

  task automatic clear_rx();
    rx_byte_q.delete(); rx_par_q.delete(); rx_ok_q.delete();
    rx_len_q.delete(); rx_st_q.delete(); rx_end_q.delete();
    done_cnt = 0;
  endtask

  task automatic wait_rx(input int n, input int max_cyc, output bit ok);
    int c = 0;
    while (rx_byte_q.size() < n && c < max_cyc) begin
      @(negedge Clk);
      c++;
    end
    ok = (rx_byte_q.size() >= n);
  endtask

  task automatic wait_busy(input int max_cyc, output bit ok);
    int c = 0;
    while (Uart_state !== 1'b1 && c < max_cyc) begin
      @(negedge Clk);
      c++;
    end
    ok = (Uart_state === 1'b1);
  endtask

  task automatic write_byte(input logic [7:0] d);
    @(negedge Clk); Wr_en = 1'b1; Data_byte = d;
    @(negedge Clk); Wr_en = 1'b0;
  endtask

  task automatic test_reset();
    #1 Rst_n = 1'b0;
    #2;
    n_checks++; if (Uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", Uart_tx); end
    n_checks++; if (Uart_tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", Uart_tx_done); end
    n_checks++; if (Uart_state !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %b want 0", Uart_state); end
    n_checks++; if (Empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", Empty); end
    n_checks++; if (Full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", Full); end
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_divisors();
    int exp50 [8] = '{5208, 2604, 1302, 868, 434, 5208, 5208, 5208};
    int exptb [8] = '{120, 60, 30, 20, 10, 120, 120, 120};
    int got;
    for (int s = 0; s < 8; s++) begin
      got = int'(baud_div(50_000_000, 3'(s)));
      n_checks++; if (got !== exp50[s]) begin n_fail++; $display("FAIL div50M_sel%0d: got %0d want %0d", s, got, exp50[s]); end
      got = int'(baud_div(TB_CLK_HZ, 3'(s)));
      n_checks++; if (got !== exptb[s]) begin n_fail++; $display("FAIL divtb_sel%0d: got %0d want %0d", s, got, exptb[s]); end
    end
  endtask

  task automatic test_single();
    bit ok;
    clear_rx();
    Baud_sel = 3'd4; Parity_en = 1'b0; rx_par_en = 1'b0;
    @(negedge Clk); Wr_en = 1'b1; Data_byte = 8'hFE;
    @(negedge Clk); Wr_en = 1'b0;
    n_checks++; if (Empty !== 1'b0) begin n_fail++; $display("FAIL single_empty_c0: got %b want 0", Empty); end
    n_checks++; if (Uart_tx !== 1'b1) begin n_fail++; $display("FAIL single_tx_c0: got %b want 1", Uart_tx); end
    @(negedge Clk);
    n_checks++; if (Uart_tx !== 1'b1) begin n_fail++; $display("FAIL single_tx_c1: got %b want 1", Uart_tx); end
    @(negedge Clk);
    n_checks++; if (Uart_tx !== 1'b0) begin n_fail++; $display("FAIL single_tx_c2: got %b want 0", Uart_tx); end
    n_checks++; if (Uart_state !== 1'b1) begin n_fail++; $display("FAIL single_state_c2: got %b want 1", Uart_state); end
    wait_rx(1, 300, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_timeout: got %0d frames want 1", rx_byte_q.size()); end
    if (ok) begin
      n_checks++; if (rx_byte_q[0] !== 8'hFE) begin n_fail++; $display("FAIL single_byte: got %h want fe", rx_byte_q[0]); end
      n_checks++; if (rx_len_q[0] !== 100) begin n_fail++; $display("FAIL single_len: got %0d want 100", rx_len_q[0]); end
      n_checks++; if (rx_ok_q[0] !== 1'b1) begin n_fail++; $display("FAIL single_shape: got %b want 1", rx_ok_q[0]); end
    end
    repeat (3) @(negedge Clk);
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt); end
    n_checks++; if (Uart_state !== 1'b0) begin n_fail++; $display("FAIL single_state_end: got %b want 0", Uart_state); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v [4] = '{8'hAA, 8'h55, 8'h77, 8'h00};
    bit ok;
    clear_rx();
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk); Wr_en = 1'b1; Data_byte = v[i];
    end
    @(negedge Clk); Wr_en = 1'b0;
    wait_rx(4, 800, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL burst_timeout: got %0d frames want 4", rx_byte_q.size()); end
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        n_checks++; if (rx_byte_q[i] !== v[i]) begin n_fail++; $display("FAIL burst_byte%0d: got %h want %h", i, rx_byte_q[i], v[i]); end
        n_checks++; if (rx_len_q[i] !== 100 || rx_ok_q[i] !== 1'b1) begin n_fail++; $display("FAIL burst_frame%0d: got len %0d shape %b want 100 1", i, rx_len_q[i], rx_ok_q[i]); end
        if (i > 0) begin
          n_checks++; if (rx_st_q[i] !== rx_end_q[i-1] + 1) begin n_fail++; $display("FAIL burst_gap%0d: got start %0d want %0d", i, rx_st_q[i], rx_end_q[i-1] + 1); end
        end
      end
      n_checks++; if (rx_end_q[3] - rx_st_q[0] + 1 !== 400) begin n_fail++; $display("FAIL burst_span: got %0d want 400", rx_end_q[3] - rx_st_q[0] + 1); end
    end
    repeat (3) @(negedge Clk);
    n_checks++; if (done_cnt !== 4) begin n_fail++; $display("FAIL burst_done_cnt: got %0d want 4", done_cnt); end
  endtask

  task automatic test_overflow();
    bit ok;
    clear_rx();
    write_byte(8'h10);
    wait_busy(50, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ovf_busy: got %b want 1", Uart_state); end
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (i > 0) begin
        n_checks++; if (Full !== (i >= DEPTH)) begin n_fail++; $display("FAIL ovf_full_after%0d: got %b want %b", i, Full, (i >= DEPTH)); end
      end
      Wr_en = 1'b1; Data_byte = 8'h20 + 8'(i);
    end
    @(negedge Clk); Wr_en = 1'b0;
    n_checks++; if (Full !== 1'b1) begin n_fail++; $display("FAIL ovf_full_after10: got %b want 1", Full); end
    wait_rx(9, 2000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ovf_timeout: got %0d frames want 9", rx_byte_q.size()); end
    if (ok) begin
      n_checks++; if (rx_byte_q[0] !== 8'h10) begin n_fail++; $display("FAIL ovf_byte0: got %h want 10", rx_byte_q[0]); end
      for (int i = 1; i < 9; i++) begin
        n_checks++; if (rx_byte_q[i] !== 8'h1F + 8'(i)) begin n_fail++; $display("FAIL ovf_byte%0d: got %h want %h", i, rx_byte_q[i], 8'h1F + 8'(i)); end
      end
    end
    repeat (300) @(negedge Clk);
    n_checks++; if (rx_byte_q.size() !== 9) begin n_fail++; $display("FAIL ovf_frames: got %0d want 9", rx_byte_q.size()); end
    n_checks++; if (done_cnt !== 9) begin n_fail++; $display("FAIL ovf_done_cnt: got %0d want 9", done_cnt); end
    n_checks++; if (Empty !== 1'b1 || Full !== 1'b0) begin n_fail++; $display("FAIL ovf_flags_end: got empty %b full %b want 1 0", Empty, Full); end
  endtask

  task automatic test_parity();
    logic [7:0] d [3] = '{8'h01, 8'h01, 8'h03};
    bit odd [3] = '{1'b0, 1'b1, 1'b0};
    bit ep  [3] = '{1'b1, 1'b0, 1'b0};
    bit ok;
    Parity_en = 1'b1; rx_par_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clear_rx();
      Parity_odd = odd[i];
      write_byte(d[i]);
      wait_rx(1, 400, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL par%0d_timeout: got %0d frames want 1", i, rx_byte_q.size()); end
      if (ok) begin
        n_checks++; if (rx_byte_q[0] !== d[i]) begin n_fail++; $display("FAIL par%0d_byte: got %h want %h", i, rx_byte_q[0], d[i]); end
        n_checks++; if (rx_par_q[0] !== ep[i]) begin n_fail++; $display("FAIL par%0d_bit: got %b want %b", i, rx_par_q[0], ep[i]); end
        n_checks++; if (rx_len_q[0] !== 110 || rx_ok_q[0] !== 1'b1) begin n_fail++; $display("FAIL par%0d_frame: got len %0d shape %b want 110 1", i, rx_len_q[0], rx_ok_q[0]); end
      end
      repeat (3) @(negedge Clk);
    end
    Parity_en = 1'b0; Parity_odd = 1'b0; rx_par_en = 1'b0;
  endtask

  task automatic test_rate_change();
    bit ok;
    clear_rx();
    Baud_sel = 3'd4;
    @(negedge Clk); Wr_en = 1'b1; Data_byte = 8'h5A;
    @(negedge Clk); Data_byte = 8'hC3;
    @(negedge Clk); Wr_en = 1'b0;
    wait_busy(50, ok);
    repeat (30) @(negedge Clk);
    Baud_sel = 3'd0;
    wait_rx(2, 1600, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rate_timeout: got %0d frames want 2", rx_byte_q.size()); end
    if (ok) begin
      n_checks++; if (rx_byte_q[0] !== 8'h5A || rx_len_q[0] !== 100) begin n_fail++; $display("FAIL rate_frame0: got %h len %0d want 5a len 100", rx_byte_q[0], rx_len_q[0]); end
      n_checks++; if (rx_byte_q[1] !== 8'hC3 || rx_len_q[1] !== 1200) begin n_fail++; $display("FAIL rate_frame1: got %h len %0d want c3 len 1200", rx_byte_q[1], rx_len_q[1]); end
      n_checks++; if (rx_ok_q[1] !== 1'b1) begin n_fail++; $display("FAIL rate_shape1: got %b want 1", rx_ok_q[1]); end
    end
    Baud_sel = 3'd4;
    repeat (3) @(negedge Clk);
  endtask

  task automatic test_mid_reset();
    bit ok;
    clear_rx();
    @(negedge Clk); Wr_en = 1'b1; Data_byte = 8'h34;
    @(negedge Clk); Data_byte = 8'h99;
    @(negedge Clk); Wr_en = 1'b0;
    wait_busy(50, ok);
    repeat (45) @(negedge Clk);
    n_checks++; if (Uart_tx !== 1'b0) begin n_fail++; $display("FAIL rst_d3_level: got %b want 0", Uart_tx); end
    Rst_n = 1'b0;
    #1;
    n_checks++; if (Uart_tx !== 1'b1) begin n_fail++; $display("FAIL rst_mid_tx: got %b want 1", Uart_tx); end
    n_checks++; if (Empty !== 1'b1) begin n_fail++; $display("FAIL rst_mid_empty: got %b want 1", Empty); end
    n_checks++; if (Uart_state !== 1'b0) begin n_fail++; $display("FAIL rst_mid_state: got %b want 0", Uart_state); end
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (200) @(negedge Clk);
    n_checks++; if (rx_byte_q.size() !== 0 || done_cnt !== 0) begin n_fail++; $display("FAIL rst_no_frame: got frames %0d done %0d want 0 0", rx_byte_q.size(), done_cnt); end
    n_checks++; if (Uart_tx !== 1'b1 || Empty !== 1'b1) begin n_fail++; $display("FAIL rst_idle_after: got tx %b empty %b want 1 1", Uart_tx, Empty); end
    write_byte(8'h81);
    wait_rx(1, 300, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_next_timeout: got %0d frames want 1", rx_byte_q.size()); end
    if (ok) begin
      n_checks++; if (rx_byte_q[0] !== 8'h81 || rx_len_q[0] !== 100 || rx_ok_q[0] !== 1'b1) begin n_fail++; $display("FAIL rst_next_frame: got %h len %0d shape %b want 81 100 1", rx_byte_q[0], rx_len_q[0], rx_ok_q[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_divisors();
    test_single();
    test_back_to_back();
    test_overflow();
    test_parity();
    test_rate_change();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion want completion before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
